// File: rtl/mmio_cmd_master_pkg.sv
// Shared constants and state type for the UART-driven MMIO command master.
package mmio_cmd_pkg;

   // Frame opcodes sent by the host.
   localparam logic [7:0] OP_WR   = 8'h57;  // 'W'
   localparam logic [7:0] OP_RD   = 8'h52;  // 'R'

   // Single-byte responses returned to the host.
   localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
   localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

   // Frame sequencer states.
   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_BUS,
      S_RESP
   } state_e;

endpackage

// File: rtl/mmio_cmd_master_if.sv
// Byte-stream and MMIO bus signals of the command master, grouped as one
// interface. The master modport is the command master's view; the slave
// modport is the view of the FIFOs and slot bus surrounding it.
interface mmio_cmd_master_if;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        mmio_cs;
   logic        mmio_wr;
   logic        mmio_rd;
   logic [20:0] mmio_addr;
   logic [31:0] mmio_wr_data;
   logic [31:0] mmio_rd_data;

   modport master (
      input  rx_data, rx_valid, tx_ready, mmio_rd_data,
      output rx_ready, tx_data, tx_valid,
             mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, mmio_rd_data,
      input  rx_ready, tx_data, tx_valid,
             mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
   );

endinterface

// File: rtl/mmio_cmd_master.sv
// UART byte-stream command initiator for the FPro MMIO bus.
// Write frame: 57 A2 A1 A0 D3 D2 D1 D0 -> one write cycle, reply 4B.
// Read frame : 52 A2 A1 A0             -> one read cycle, reply 4 data bytes.
// Any other lead byte replies 45 and pulses frame_err. A stalled frame is
// abandoned after TIMEOUT_CYC idle cycles (0 disables the timeout).
module mmio_cmd_master
   import mmio_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
   input  logic               clk,
   input  logic               reset,
   mmio_cmd_master_if.master  cmd_if,
   output logic               busy,
   output logic               frame_err
);

   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
   localparam logic        TMO_EN   = (TIMEOUT_CYC != 0);

   state_e      state_q, state_d;
   logic        is_wr_q, is_wr_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] addr_sh_q, addr_sh_d;
   logic [31:0] data_sh_q, data_sh_d;
   logic [20:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [31:0] resp_q, resp_d;
   logic [2:0]  resp_left_q, resp_left_d;
   logic [31:0] tmr_q, tmr_d;
   logic        frame_err_q, frame_err_d;

   logic        rx_acc;
   logic        tx_acc;
   logic        expire;

   // Output decode: handshakes and strobes depend on state only, so there is
   // no combinational path from rx_valid/tx_ready back to rx_ready/tx_valid.
   assign cmd_if.rx_ready     = (state_q == S_IDLE) || (state_q == S_ADDR) ||
                                (state_q == S_DATA);
   assign cmd_if.tx_valid     = (state_q == S_RESP);
   assign cmd_if.tx_data      = resp_q[31:24];
   assign cmd_if.mmio_cs      = (state_q == S_BUS);
   assign cmd_if.mmio_wr      = (state_q == S_BUS) && is_wr_q;
   assign cmd_if.mmio_rd      = (state_q == S_BUS) && !is_wr_q;
   assign cmd_if.mmio_addr    = bus_addr_q;
   assign cmd_if.mmio_wr_data = bus_wdata_q;
   assign busy                = (state_q != S_IDLE);
   assign frame_err           = frame_err_q;

   assign rx_acc = cmd_if.rx_valid && cmd_if.rx_ready;
   assign tx_acc = cmd_if.tx_valid && cmd_if.tx_ready;
   assign expire = TMO_EN && (tmr_q == TMO_LAST);

   // Next-state logic: frame parsing, bus cycle, response shift-out, timeout.
   always_comb begin
      state_d     = state_q;
      is_wr_d     = is_wr_q;
      cnt_d       = cnt_q;
      addr_sh_d   = addr_sh_q;
      data_sh_d   = data_sh_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      resp_d      = resp_q;
      resp_left_d = resp_left_q;
      tmr_d       = '0;
      frame_err_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (rx_acc) begin
               if (cmd_if.rx_data == OP_WR || cmd_if.rx_data == OP_RD) begin
                  is_wr_d = (cmd_if.rx_data == OP_WR);
                  cnt_d   = '0;
                  state_d = S_ADDR;
               end else begin
                  resp_d      = {RSP_ERR, 24'h0};
                  resp_left_d = 3'd1;
                  frame_err_d = 1'b1;
                  state_d     = S_RESP;
               end
            end
         end

         S_ADDR: begin
            // An accepted byte wins over expiry in the same cycle.
            if (rx_acc) begin
               addr_sh_d = {addr_sh_q[15:0], cmd_if.rx_data};
               if (cnt_q == 2'd2) begin
                  cnt_d = '0;
                  if (is_wr_q) begin
                     state_d = S_DATA;
                  end else begin
                     // A2[7:5] fall off the top of the 21-bit bus address.
                     bus_addr_d = {addr_sh_q[12:0], cmd_if.rx_data};
                     state_d    = S_BUS;
                  end
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end else if (expire) begin
               frame_err_d = 1'b1;
               state_d     = S_IDLE;
            end else if (TMO_EN) begin
               tmr_d = tmr_q + 32'd1;
            end
         end

         S_DATA: begin
            if (rx_acc) begin
               data_sh_d = {data_sh_q[23:0], cmd_if.rx_data};
               if (cnt_q == 2'd3) begin
                  cnt_d       = '0;
                  bus_addr_d  = addr_sh_q[20:0];
                  bus_wdata_d = {data_sh_q[23:0], cmd_if.rx_data};
                  state_d     = S_BUS;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end else if (expire) begin
               frame_err_d = 1'b1;
               state_d     = S_IDLE;
            end else if (TMO_EN) begin
               tmr_d = tmr_q + 32'd1;
            end
         end

         S_BUS: begin
            if (is_wr_q) begin
               resp_d      = {RSP_OK, 24'h0};
               resp_left_d = 3'd1;
            end else begin
               resp_d      = cmd_if.mmio_rd_data;
               resp_left_d = 3'd4;
            end
            state_d = S_RESP;
         end

         S_RESP: begin
            if (tx_acc) begin
               resp_d      = {resp_q[23:0], 8'h00};
               resp_left_d = resp_left_q - 3'd1;
               if (resp_left_q == 3'd1) begin
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         is_wr_q     <= 1'b0;
         cnt_q       <= '0;
         addr_sh_q   <= '0;
         data_sh_q   <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         resp_q      <= '0;
         resp_left_q <= '0;
         tmr_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_wr_q     <= is_wr_d;
         cnt_q       <= cnt_d;
         addr_sh_q   <= addr_sh_d;
         data_sh_q   <= data_sh_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         resp_q      <= resp_d;
         resp_left_q <= resp_left_d;
         tmr_q       <= tmr_d;
         frame_err_q <= frame_err_d;
      end
   end

endmodule

// File: tb/tb_mmio_cmd_master.sv
// Scoreboard bench for mmio_cmd_master: frame-level stimulus pushes expected
// bus cycles, response bytes and error pulses; a monitor compares them.
module tb_mmio_cmd_master;
   import mmio_cmd_pkg::*;

   localparam int unsigned TMO = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic busy;
   logic frame_err;

   mmio_cmd_master_if dif ();

   mmio_cmd_master #(.TIMEOUT_CYC(TMO)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_if    (dif),
      .busy      (busy),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst_seen = 1'b0;
   always @(posedge clk) rst_seen <= !reset;

   // Slot register contents as seen by the bus: a fixed function of address.
   function automatic logic [31:0] slot_val(input logic [20:0] a);
      return {a[7:0], a[20:13], ~a[12:5], a[7:0] ^ 8'h5A};
   endfunction

   logic [31:0] junk = 32'h0;
   always @(posedge clk) junk <= $urandom;
   assign dif.mmio_rd_data = (dif.mmio_cs && dif.mmio_rd) ? slot_val(dif.mmio_addr) : junk;

   typedef struct {
      logic        wr;
      logic [20:0] addr;
      logic [31:0] wdata;
      int unsigned cyc;
   } bus_exp_t;

   bus_exp_t    bus_q[$];
   logic [7:0]  tx_q[$];
   int unsigned err_q[$];

   int checks   = 0;
   int failures = 0;
   int txr_mode = 0;  // 0 random, 1 held low, 2 pattern 0,0,1

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // tx_ready driver
   initial begin : txr_drv
      dif.tx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (txr_mode)
            0:       dif.tx_ready = ($urandom_range(0, 9) < 6);
            1:       dif.tx_ready = 1'b0;
            default: dif.tx_ready = (cyc % 3 == 2);
         endcase
      end
   end

   // Monitor: compares every DUT output event against the scoreboard queues.
   initial begin : monitor
      logic [20:0] last_a;
      logic [31:0] last_d;
      logic        pend;
      logic [7:0]  pend_d;
      logic        txv_chk;
      int unsigned txv_cyc;
      bus_exp_t    e;
      logic [7:0]  eb;
      int unsigned ec;
      last_a = '0; last_d = '0; pend = 1'b0; pend_d = '0; txv_chk = 1'b0; txv_cyc = 0;
      forever begin
         @(negedge clk);
         if (rst_seen) begin
            chk("rst_rx_ready", dif.rx_ready, 1);
            chk("rst_tx_valid", dif.tx_valid, 0);
            chk("rst_tx_data", dif.tx_data, 0);
            chk("rst_cs", {dif.mmio_cs, dif.mmio_wr, dif.mmio_rd}, 0);
            chk("rst_addr", dif.mmio_addr, 0);
            chk("rst_wdata", dif.mmio_wr_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_frame_err", frame_err, 0);
            last_a = '0; last_d = '0; pend = 1'b0; txv_chk = 1'b0;
         end else begin
            if (pend) begin
               chk("tx_hold_valid", dif.tx_valid, 1);
               chk("tx_hold_data", dif.tx_data, pend_d);
            end
            if (txv_chk && cyc == txv_cyc) begin
               chk("resp_latency", dif.tx_valid, 1);
               txv_chk = 1'b0;
            end
            if (dif.mmio_cs) begin
               chk("rx_ready_in_bus", dif.rx_ready, 0);
               chk("busy_in_bus", busy, 1);
               if (bus_q.size() == 0) begin
                  chk("unexpected_bus_cycle", 1, 0);
               end else begin
                  e = bus_q.pop_front();
                  chk("bus_wr", dif.mmio_wr, e.wr);
                  chk("bus_rd", dif.mmio_rd, !e.wr);
                  chk("bus_addr", dif.mmio_addr, e.addr);
                  chk("bus_cycle", cyc, e.cyc);
                  if (e.wr) begin
                     chk("bus_wdata", dif.mmio_wr_data, e.wdata);
                     last_d = e.wdata;
                  end else begin
                     chk("bus_wdata_held", dif.mmio_wr_data, last_d);
                  end
                  last_a  = e.addr;
                  txv_chk = 1'b1;
                  txv_cyc = cyc + 1;
               end
            end else begin
               chk("addr_hold", dif.mmio_addr, last_a);
               chk("wdata_hold", dif.mmio_wr_data, last_d);
               chk("no_strobe", {dif.mmio_wr, dif.mmio_rd}, 0);
            end
            if (dif.tx_valid) begin
               chk("rx_ready_in_resp", dif.rx_ready, 0);
               chk("busy_in_resp", busy, 1);
               if (dif.tx_ready) begin
                  pend = 1'b0;
                  if (tx_q.size() == 0) begin
                     chk("unexpected_tx_byte", 1, 0);
                  end else begin
                     eb = tx_q.pop_front();
                     chk("tx_byte", dif.tx_data, eb);
                  end
               end else begin
                  pend   = 1'b1;
                  pend_d = dif.tx_data;
               end
            end else begin
               pend = 1'b0;
            end
            if (frame_err) begin
               if (err_q.size() == 0) begin
                  chk("unexpected_frame_err", 1, 0);
               end else begin
                  ec = err_q.pop_front();
                  chk("frame_err_cycle", cyc, ec);
               end
            end
         end
      end
   end

   // Present one byte and return the cycle number following its acceptance.
   task automatic send_byte(input logic [7:0] b, output int unsigned acc);
      int unsigned w;
      w = 0;
      dif.rx_data  = b;
      dif.rx_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (dif.rx_ready) break;
         w++;
         if (w > 5000) begin
            chk("rx_accept_bound", 0, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      dif.rx_valid = 1'b0;
      dif.rx_data  = 8'($urandom);
      acc = cyc;
   endtask

   task automatic idle(input int g);
      if (g > 0) begin
         repeat (g) @(posedge clk);
         #1;
      end
   endtask

   function automatic int rand_gap();
      int r;
      r = $urandom_range(0, 19);
      if (r < 14) return 0;
      if (r < 18) return $urandom_range(1, 3);
      if (r == 18) return TMO - 2;
      return TMO - 1;
   endfunction

   // kind: 0 write, 1 read, 2 bad opcode. abort_at>0 stalls after that many
   // bytes for abort_gap cycles (>= TMO) and abandons the frame.
   task automatic run_frame(input int kind, input logic [23:0] a, input logic [31:0] d,
                            input int abort_at, input int abort_gap, input int fixed_gap);
      logic [7:0]  fb [8];
      logic [7:0]  op;
      logic [31:0] rv;
      int          n;
      int unsigned acc;
      bus_exp_t    e;
      acc = 0;
      if (kind == 2) begin
         op = 8'($urandom);
         while (op == OP_WR || op == OP_RD) op = 8'($urandom);
         send_byte(op, acc);
         err_q.push_back(acc);
         tx_q.push_back(RSP_ERR);
         return;
      end
      op = (kind == 0) ? OP_WR : OP_RD;
      n  = (kind == 0) ? 8 : 4;
      fb[0] = op;          fb[1] = a[23:16];    fb[2] = a[15:8];    fb[3] = a[7:0];
      fb[4] = d[31:24];    fb[5] = d[23:16];    fb[6] = d[15:8];    fb[7] = d[7:0];
      for (int i = 0; i < n; i++) begin
         if (abort_at > 0 && i == abort_at) begin
            err_q.push_back(acc + TMO);
            idle(abort_gap);
            return;
         end
         if (i != 0) idle(fixed_gap >= 0 ? fixed_gap : rand_gap());
         send_byte(fb[i], acc);
      end
      e.wr    = (kind == 0);
      e.addr  = a[20:0];
      e.wdata = d;
      e.cyc   = acc;
      bus_q.push_back(e);
      if (kind == 0) begin
         tx_q.push_back(RSP_OK);
      end else begin
         rv = slot_val(a[20:0]);
         for (int k = 3; k >= 0; k--) tx_q.push_back(rv[k*8 +: 8]);
      end
   endtask

   task automatic drain();
      int unsigned w;
      w = 0;
      while ((tx_q.size() != 0 || bus_q.size() != 0 || err_q.size() != 0) && w < 3000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 3000) chk("drain_bound", 0, 1);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_rx_ready", dif.rx_ready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b1;
      tx_q.delete();
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int unsigned acc;
      int          w;
      int          kind;
      int          nb;
      dif.rx_valid = 1'b0;
      dif.rx_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      // Directed write and read
      run_frame(0, 24'h00_00_84, 32'hDEAD_BEEF, 0, 0, 0);
      drain();
      run_frame(1, 24'hE0_00_60, '0, 0, 0, 0);
      drain();

      // Bad opcode then a normal read
      run_frame(2, '0, '0, 0, 0, 0);
      run_frame(1, 24'h00_00_00, '0, 0, 0, 0);
      drain();

      // Timeout: 57 00 then exactly TMO idle cycles
      run_frame(0, 24'h00_12_34, 32'h1, 2, TMO, 0);
      drain();
      // Byte arriving on the last cycles before expiry continues the frame
      run_frame(0, 24'h01_02_03, 32'hCAFE_F00D, 0, 0, TMO - 2);
      run_frame(1, 24'h1F_FF_FF, '0, 0, 0, TMO - 1);
      drain();

      // Backpressure on the read response
      txr_mode = 2;
      run_frame(1, 24'h03_21_40, '0, 0, 0, 0);
      drain();
      txr_mode = 0;

      // Reset mid-frame, then a full read
      send_byte(OP_WR, acc);
      send_byte(8'h00, acc);
      send_byte(8'h00, acc);
      send_byte(8'h84, acc);
      send_byte(8'hDE, acc);
      do_reset(2);
      run_frame(1, 24'h00_00_84, '0, 0, 0, 0);
      drain();

      // Reset while a response is pending
      txr_mode = 1;
      @(posedge clk);
      #1;
      run_frame(1, 24'h00_01_23, '0, 0, 0, 0);
      w = 0;
      while (!dif.tx_valid && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("resp_pending_before_reset", dif.tx_valid, 1);
      do_reset(2);
      txr_mode = 0;
      drain();

      // Randomized frames
      for (int f = 0; f < 80; f++) begin
         kind = $urandom_range(0, 9);
         if (kind < 4) begin
            run_frame(0, 24'($urandom), $urandom, 0, 0, -1);
         end else if (kind < 8) begin
            run_frame(1, 24'($urandom), '0, 0, 0, -1);
         end else if (kind == 8) begin
            run_frame(2, '0, '0, 0, 0, -1);
         end else begin
            nb = $urandom_range(0, 1);
            run_frame(nb, 24'($urandom), $urandom,
                      $urandom_range(1, nb == 0 ? 7 : 3), TMO + $urandom_range(0, 3), -1);
         end
         if ($urandom_range(0, 7) == 0) drain();
      end
      drain();

      chk("bus_q_empty", bus_q.size(), 0);
      chk("tx_q_empty", tx_q.size(), 0);
      chk("err_q_empty", err_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmio_cmd_master.md
Name: mmio_cmd_master

Overview:
- Byte-stream command initiator that drives the FPro MMIO bus (mmio_cs/wr/rd/addr/wr_data, returns mmio_rd_data).
- Lets a host debugger, fed from the UART byte stream, peek and poke any slot register without the CPU.
- Sits between UART rx/tx byte FIFOs and the MMIO subsystem bus input, muxed with the CPU port at top level.
- It is the initiator on the bus whose responders are the slot cores.

Parameters:
- TIMEOUT_CYC, 100_000_000, inter-byte timeout in clk cycles while mid-frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- rx_data  in  8  command byte from UART receive FIFO
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready at rising edge
- tx_data  out  8  response byte to UART transmit FIFO
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  byte taken when tx_valid && tx_ready at rising edge
- mmio_cs  out  1  bus select
- mmio_wr  out  1  write strobe
- mmio_rd  out  1  read strobe
- mmio_addr  out  21  bus address (slot = [10:5], reg = [4:0])
- mmio_wr_data  out  32  write data
- mmio_rd_data  in  32  read data, combinational from the addressed slot
- busy  out  1  high in any state other than IDLE
- frame_err  out  1  one-cycle pulse on bad opcode or timeout

Behaviour:
- Reset values (reset==0): state IDLE; every output 0 except rx_ready=1; all counters and shift registers 0.
- Frame format, big-endian:
  - Write: 0x57, A2, A1, A0, D3, D2, D1, D0.
  - Read: 0x52, A2, A1, A0.
  - mmio_addr = {A2[4:0],A1,A0}; A2[7:5] are ignored.
- States: IDLE, ADDR, DATA, BUS, RESP.
- IDLE:
  - rx_ready=1.
  - Byte 0x57 or 0x52 → latch opcode, go to ADDR with byte count 0.
  - Any other byte → tx byte 0x45, pulse frame_err, go to RESP with length 1.
- ADDR:
  - rx_ready=1; shift in 3 bytes.
  - After the 3rd byte: write → DATA; read → BUS.
- DATA: rx_ready=1; shift in 4 bytes, then go to BUS.
- BUS: exactly one cycle.
  - Outputs: mmio_cs=1, mmio_wr=(op==W), mmio_rd=(op==R); mmio_addr and mmio_wr_data driven from latched registers.
  - Read: mmio_rd_data is captured at the rising edge that ends the BUS cycle.
  - Next state RESP. Write response is 0x4B (length 1); read response is the 4 captured bytes, MSB first.
  - mmio_cs/wr/rd are 0 in every other state.
  - mmio_addr and mmio_wr_data hold their last value outside BUS.
- RESP:
  - rx_ready=0; tx_valid=1; tx_data stable until accepted.
  - Each handshake advances one byte; after the last byte go to IDLE (tx_valid=0 that cycle).
  - No bound on tx backpressure; the timeout does not apply in RESP.
- rx_ready=0 in BUS and RESP, so there is no command pipelining.
- Timeout (TIMEOUT_CYC>0):
  - A counter clears on every accepted byte and in IDLE, and increments each cycle in ADDR/DATA.
  - When it reaches TIMEOUT_CYC: go to IDLE, pulse frame_err, no bus access, no response.
  - A byte accepted in the same cycle as expiry takes priority, so the counter clears and the frame continues.
- Reset mid-frame: immediately IDLE, partial frame discarded, no bus strobe.
  - A pending tx byte is dropped: tx_valid goes to 0 the cycle after reset is sampled.
- Bus latency: write strobe occurs 1 cycle after the last frame byte is accepted; the read response's first tx_valid occurs 2 cycles after the last frame byte.

Decomposition:
- Package mmio_cmd_pkg:
  - Opcode constants OP_WR=8'h57, OP_RD=8'h52.
  - Response constants RSP_OK=8'h4B, RSP_ERR=8'h45.
  - State enum typedef.
- Single flat module; no sub-module. The byte shift-in and shift-out registers are small enough to stay inline.

Test Plan:
- Write: rx 57 00 00 84 DE AD BE EF → one cycle cs=1, wr=1, rd=0, addr=0x00084, wr_data=0xDEADBEEF; then tx 0x4B; busy falls after it is accepted.
- Read: rx 52 E0 00 60 with mmio_rd_data=0x12345678 during BUS → one cycle cs=1, rd=1, addr=0x00060 (upper bits ignored); tx 12 34 56 78 in order.
- Bad opcode: rx 0x41 → tx 0x45, frame_err pulse, no cs; next frame 52 00 00 00 processes normally.
- Timeout with TIMEOUT_CYC=16: rx 57 00 then idle 16 cycles → frame_err pulse, back to IDLE, no cs. A byte arriving on cycle 15 continues the frame.
- Backpressure: read frame with tx_ready toggling 0,0,1 per byte → tx_data holds each byte until taken, rx_ready=0 throughout, 4 bytes delivered.
- Reset mid-operation: drop reset to 0 after rx 57 00 00 84 DE, then release and send a full read frame → no write strobe ever; the read completes normally.
